// File: rtl/anurv_pkg.sv
// Shared decode types and opcode constants for the anurv RV32I front end.
package anurv_pkg;

  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_FENCE  = 5'b00011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  typedef enum logic [3:0] {
    OcLui, OcAuipc, OcJal, OcJalr, OcBranch, OcLoad,
    OcStore, OcOpimm, OcOp, OcFence, OcSystem, OcIllegal
  } opclass_t;

  typedef enum logic [2:0] {ImmI, ImmS, ImmB, ImmU, ImmJ, ImmNone} imm_fmt_t;

  typedef struct packed {
    opclass_t opclass;
    imm_fmt_t fmt;
    logic     wr_class;  // class writes rd (before the rd != 0 qualification)
    logic     uses_rs1;
    logic     uses_rs2;
  } dec_t;

  function automatic dec_t decode(input logic [6:0] opcode);
    dec_t d;
    d = '{opclass: OcIllegal, fmt: ImmNone, wr_class: 1'b0, uses_rs1: 1'b1, uses_rs2: 1'b0};
    if (opcode[1:0] == 2'b11) begin
      case (opcode[6:2])
        OPC_LUI:    d = '{OcLui,    ImmU,    1'b1, 1'b0, 1'b0};
        OPC_AUIPC:  d = '{OcAuipc,  ImmU,    1'b1, 1'b0, 1'b0};
        OPC_JAL:    d = '{OcJal,    ImmJ,    1'b1, 1'b0, 1'b0};
        OPC_JALR:   d = '{OcJalr,   ImmI,    1'b1, 1'b1, 1'b0};
        OPC_BRANCH: d = '{OcBranch, ImmB,    1'b0, 1'b1, 1'b1};
        OPC_LOAD:   d = '{OcLoad,   ImmI,    1'b1, 1'b1, 1'b0};
        OPC_STORE:  d = '{OcStore,  ImmS,    1'b0, 1'b1, 1'b1};
        OPC_OPIMM:  d = '{OcOpimm,  ImmI,    1'b1, 1'b1, 1'b0};
        OPC_OP:     d = '{OcOp,     ImmNone, 1'b1, 1'b1, 1'b1};
        OPC_FENCE:  d = '{OcFence,  ImmI,    1'b0, 1'b0, 1'b0};
        OPC_SYSTEM: d = '{OcSystem, ImmI,    1'b1, 1'b1, 1'b0};
        default:    d = '{OcIllegal, ImmNone, 1'b0, 1'b1, 1'b0};
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator for the I/S/B/U/J formats.
module imm_gen
  import anurv_pkg::*;
(
  input  logic [31:0] instr,
  input  imm_fmt_t    fmt,
  output logic [31:0] imm
);

  logic unused_opc;
  assign unused_opc = ^instr[6:0];

  always_comb begin
    imm = '0;
    case (fmt)
      ImmI:    imm = {{20{instr[31]}}, instr[31:20]};
      ImmS:    imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      ImmB:    imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      ImmU:    imm = {instr[31:12], 12'b0};
      ImmJ:    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: register-file read, scoreboard hazard stall, ID/EX register.
// Optional ANURV_WB_BYPASS_EN forwards same-cycle writeback data and ends the stall early.
module id_stage
  import anurv_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic [4:0]      rf_rs1,
  output logic [4:0]      rf_rs2,
  output logic            rf_ren,
  input  logic [XLEN-1:0] rf_o1,
  input  logic [XLEN-1:0] rf_o2,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_op1,
  output logic [XLEN-1:0] ex_op2,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic [3:0]      ex_opclass,
  output logic [2:0]      ex_funct3,
  output logic            ex_alt
);

  logic [4:0]      rd;
  dec_t            dec;
  logic [31:0]     imm;
  logic            writes_rd;
  logic [NREG-1:0] pend_q, pend_d, pend_eff, wb_mask, set_mask;
  logic            hazard, fire;
  logic [XLEN-1:0] op1, op2;

  assign rf_rs1 = if_instr[19:15];
  assign rf_rs2 = if_instr[24:20];
  assign rf_ren = if_valid;
  assign rd     = if_instr[11:7];

  assign dec       = decode(if_instr[6:0]);
  assign writes_rd = dec.wr_class & (rd != 5'd0);

  imm_gen u_imm_gen (
    .instr (if_instr),
    .fmt   (dec.fmt),
    .imm   (imm)
  );

  always_comb begin
    wb_mask = '0;
    if (wb_valid && wb_rd != 5'd0) wb_mask[wb_rd] = 1'b1;
  end

`ifdef ANURV_WB_BYPASS_EN
  // A register retiring this cycle is already resolved; forward its data.
  assign pend_eff = pend_q & ~wb_mask;
  assign op1 = (wb_valid && wb_rd != 5'd0 && wb_rd == rf_rs1) ? wb_data : rf_o1;
  assign op2 = (wb_valid && wb_rd != 5'd0 && wb_rd == rf_rs2) ? wb_data : rf_o2;
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
  assign pend_eff = pend_q;
  assign op1 = rf_o1;
  assign op2 = rf_o2;
`endif

  assign hazard   = (dec.uses_rs1 & pend_eff[rf_rs1]) | (dec.uses_rs2 & pend_eff[rf_rs2]);
  assign if_ready = ~hazard & (~ex_valid | ex_ready);
  assign fire     = if_valid & if_ready;

  always_comb begin
    set_mask = '0;
    if (fire && writes_rd) set_mask[rd] = 1'b1;
  end

  // Set is applied after clear so a same-cycle set/clear on one index leaves it pending.
  assign pend_d = (pend_q & ~wb_mask) | set_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q     <= '0;
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      ex_op1     <= '0;
      ex_op2     <= '0;
      ex_imm     <= '0;
      ex_rd      <= '0;
      ex_opclass <= '0;
      ex_funct3  <= '0;
      ex_alt     <= 1'b0;
    end else begin
      pend_q <= pend_d;
      if (fire) begin
        ex_valid   <= 1'b1;
        ex_pc      <= if_pc;
        ex_op1     <= op1;
        ex_op2     <= op2;
        ex_imm     <= imm;
        ex_rd      <= writes_rd ? rd : 5'd0;
        ex_opclass <= dec.opclass;
        ex_funct3  <= if_instr[14:12];
        ex_alt     <= if_instr[30];
      end else if (ex_ready) begin
        ex_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: hand sequences for stalls/holds/reset plus a decode table.
module tb_id_stage;
  import anurv_pkg::*;

  localparam logic [31:0] RF1 = 32'h1111_1111;
  localparam logic [31:0] RF2 = 32'h2222_2222;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;
  logic [4:0]  rf_rs1, rf_rs2;
  logic        rf_ren;
  logic [31:0] rf_o1, rf_o2;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_pc, ex_op1, ex_op2, ex_imm;
  logic [4:0]  ex_rd;
  logic [3:0]  ex_opclass;
  logic [2:0]  ex_funct3;
  logic        ex_alt;

  always #5 clk = ~clk;

  id_stage #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_ren(rf_ren), .rf_o1(rf_o1), .rf_o2(rf_o2),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_op1(ex_op1),
    .ex_op2(ex_op2), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_opclass(ex_opclass),
    .ex_funct3(ex_funct3), .ex_alt(ex_alt)
  );

  typedef struct {
    logic [31:0] pc, op1, op2, imm;
    logic [4:0]  rd;
    logic [3:0]  opclass;
    logic [2:0]  f3;
    logic        alt;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  opclass;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic        alt;
  } vec_t;

  exp_t exp_q[$];
  exp_t cur_exp;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic check_ex(input exp_t e);
    check("ex_pc", ex_pc, e.pc);
    check("ex_op1", ex_op1, e.op1);
    check("ex_op2", ex_op2, e.op2);
    check("ex_imm", ex_imm, e.imm);
    check("ex_rd", {27'd0, ex_rd}, {27'd0, e.rd});
    check("ex_opclass", {28'd0, ex_opclass}, {28'd0, e.opclass});
    check("ex_funct3", {29'd0, ex_funct3}, {29'd0, e.f3});
    check("ex_alt", {31'd0, ex_alt}, {31'd0, e.alt});
  endtask

  function automatic exp_t mk(input vec_t v, input logic [31:0] pc);
    exp_t e;
    e.pc = pc; e.op1 = RF1; e.op2 = RF2; e.imm = v.imm;
    e.rd = v.rd; e.opclass = v.opclass; e.f3 = v.f3; e.alt = v.alt;
    return e;
  endfunction

  // Scoreboard: push on fire, pop when the ID/EX register is consumed.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ex_valid && ex_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got pc %h expected no output", ex_pc);
      end else begin
        e = exp_q.pop_front();
        check_ex(e);
      end
    end
    if (!rst && if_valid && if_ready) exp_q.push_back(cur_exp);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input vec_t v, input logic [31:0] pc);
    bit ok;
    ok = 1'b0;
    cur_exp  = mk(v, pc);
    if_instr = v.instr;
    if_pc    = pc;
    if_valid = 1'b1;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      ok = if_ready;
      tick();
    end
    check("issue_ready", {31'd0, ok}, 32'd1);
    if_valid = 1'b0;
  endtask

  task automatic wb(input logic [4:0] r);
    wb_valid = 1'b1;
    wb_rd    = r;
    tick();
    wb_valid = 1'b0;
  endtask

  vec_t tbl[12];
  vec_t v_addi1, v_addi8, v_lui, v_beq, v_ill, v_addi9, v_addi3a, v_addi3b;
  exp_t ill_exp;

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{32'h00001317, OcAuipc,   5'd6,  32'h00001000, 3'd1, 1'b0};
    tbl[1]  = '{32'h008000EF, OcJal,     5'd1,  32'h00000008, 3'd0, 1'b0};
    tbl[2]  = '{32'h00008067, OcJalr,    5'd0,  32'h00000000, 3'd0, 1'b0};
    tbl[3]  = '{32'hFFC12503, OcLoad,    5'd10, 32'hFFFFFFFC, 3'd2, 1'b1};
    tbl[4]  = '{32'h00B12623, OcStore,   5'd0,  32'h0000000C, 3'd2, 1'b0};
    tbl[5]  = '{32'h4033D393, OcOpimm,   5'd7,  32'h00000403, 3'd5, 1'b1};
    tbl[6]  = '{32'h40A48433, OcOp,      5'd8,  32'h00000000, 3'd0, 1'b1};
    tbl[7]  = '{32'h0FF0000F, OcFence,   5'd0,  32'h000000FF, 3'd0, 1'b0};
    tbl[8]  = '{32'h00000073, OcSystem,  5'd0,  32'h00000000, 3'd0, 1'b0};
    tbl[9]  = '{32'h30002673, OcSystem,  5'd12, 32'h00000300, 3'd2, 1'b0};
    tbl[10] = '{32'h00500091, OcIllegal, 5'd0,  32'h00000000, 3'd0, 1'b0};
    tbl[11] = '{32'h00209863, OcBranch,  5'd0,  32'h00000010, 3'd1, 1'b0};
    v_addi1  = '{32'h00500093, OcOpimm,   5'd1, 32'h00000005, 3'd0, 1'b0};
    v_addi8  = '{32'h00100413, OcOpimm,   5'd8, 32'h00000001, 3'd0, 1'b0};
    v_lui    = '{32'h123452B7, OcLui,     5'd5, 32'h12345000, 3'd5, 1'b0};
    v_beq    = '{32'hFE000EE3, OcBranch,  5'd0, 32'hFFFFFFFC, 3'd0, 1'b1};
    v_ill    = '{32'hFFFFFFFF, OcIllegal, 5'd0, 32'h00000000, 3'd7, 1'b1};
    v_addi9  = '{32'h00100493, OcOpimm,   5'd9, 32'h00000001, 3'd0, 1'b0};
    v_addi3a = '{32'h00300193, OcOpimm,   5'd3, 32'h00000003, 3'd0, 1'b0};
    v_addi3b = '{32'h00700193, OcOpimm,   5'd3, 32'h00000007, 3'd0, 1'b0};

    rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0;
    rf_o1 = RF1; rf_o2 = RF2; wb_valid = 1'b0; wb_rd = '0; wb_data = '0; ex_ready = 1'b1;
    cur_exp = mk(v_addi1, 32'h0);
    @(negedge clk);
    check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_ex_imm", ex_imm, 32'd0);
    check("rst_ex_pc", ex_pc, 32'd0);
    check("rst_ex_rd_opclass", {ex_rd, ex_opclass}, 32'd0);
    check("rst_pend", dut.pend_q, 32'd0);
    check("rst_if_ready", {31'd0, if_ready}, 32'd1);
    tick();
    rst = 1'b0;
    tick();

    // addi x1 then dependent add x2,x1,x1
    cur_exp = mk(v_addi1, 32'h100);
    if_instr = v_addi1.instr; if_pc = 32'h100; if_valid = 1'b1;
    @(negedge clk);
    check("addi_if_ready", {31'd0, if_ready}, 32'd1);
    tick();
    check("addi_pend1", {31'd0, dut.pend_q[1]}, 32'd1);
    cur_exp = '{32'h104, RF1, RF2, 32'h0, 5'd2, OcOp, 3'd0, 1'b0};
    if_instr = 32'h00108133; if_pc = 32'h104;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("stall_if_ready", {31'd0, if_ready}, 32'd0);
      check("stall_rf_rs", {22'd0, rf_ren, rf_rs1, rf_rs2}, {22'd0, 1'b1, 5'd1, 5'd1});
      tick();
    end
    wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'hDEADBEEF;
`ifdef ANURV_WB_BYPASS_EN
    cur_exp.op1 = 32'hDEADBEEF;
    cur_exp.op2 = 32'hDEADBEEF;
    @(negedge clk);
    check("wb_cycle_if_ready", {31'd0, if_ready}, 32'd1);
    tick();
    wb_valid = 1'b0; if_valid = 1'b0;
`else
    @(negedge clk);
    check("wb_cycle_if_ready", {31'd0, if_ready}, 32'd0);
    tick();
    wb_valid = 1'b0;
    @(negedge clk);
    check("after_wb_if_ready", {31'd0, if_ready}, 32'd1);
    tick();
    if_valid = 1'b0;
`endif
    wb(5'd2);

    // lui must not stall on its unused rs1 field (x8 pending)
    issue(v_addi8, 32'h200);
    cur_exp = mk(v_lui, 32'h204);
    if_instr = v_lui.instr; if_pc = 32'h204; if_valid = 1'b1;
    @(negedge clk);
    check("lui_no_stall", {31'd0, if_ready}, 32'd1);
    tick();
    if_valid = 1'b0;
    wb(5'd8);
    wb(5'd5);

    issue(v_beq, 32'h300);
    tick();
    check("beq_no_pend", dut.pend_q, 32'd0);

    // Illegal held in ID/EX for three cycles with a new instruction waiting
    issue(v_ill, 32'h400);
    ill_exp = mk(v_ill, 32'h400);
    ex_ready = 1'b0;
    cur_exp = mk(v_addi9, 32'h404);
    if_instr = v_addi9.instr; if_pc = 32'h404; if_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_if_ready", {31'd0, if_ready}, 32'd0);
      check("hold_ex_valid", {31'd0, ex_valid}, 32'd1);
      check_ex(ill_exp);
      tick();
    end
    ex_ready = 1'b1;
    tick();
    if_valid = 1'b0;
    wb(5'd9);

    // Same-cycle set and clear of x3, then reset during a stall
    issue(v_addi3a, 32'h500);
    cur_exp = mk(v_addi3b, 32'h504);
    if_instr = v_addi3b.instr; if_pc = 32'h504; if_valid = 1'b1;
    wb_valid = 1'b1; wb_rd = 5'd3;
    tick();
    wb_valid = 1'b0;
    ex_ready = 1'b0;
    cur_exp = '{32'h508, RF1, RF2, 32'h0, 5'd4, OcOp, 3'd0, 1'b0};
    if_instr = 32'h00018233; if_pc = 32'h508;
    @(negedge clk);
    check("setclr_pend3", {31'd0, dut.pend_q[3]}, 32'd1);
    check("x3_stall", {31'd0, if_ready}, 32'd0);
    #1 rst = 1'b1;
    #1;
    check("midrst_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("midrst_pend", dut.pend_q, 32'd0);
    check("midrst_if_ready", {31'd0, if_ready}, 32'd1);
    exp_q.delete();
    if_valid = 1'b0;
    ex_ready = 1'b1;
    tick();
    rst = 1'b0;
    wb(5'd3);
    check("late_wb_pend", dut.pend_q, 32'd0);

    for (int i = 0; i < 12; i++) begin
      issue(tbl[i], 32'h1000 + 32'(i) * 4);
      if (tbl[i].rd != 5'd0) wb(tbl[i].rd);
      else tick();
    end

    tick();
    tick();
    check("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
